// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, scoreboard count type and
// the hazard controller state encoding.
package cpu_pkg;

  localparam int REG_IDX_W = 6;
  localparam int NUM_REGS  = 64;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Number of in-flight writes pending against one register.
  typedef logic [1:0] sb_cnt_t;
  localparam sb_cnt_t SB_CNT_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard. Each entry counts issued writes
// that have not yet committed. Two read ports serve the ID source operands.
// Over/underflow saturates the entry and raises proto_err_o for one cycle.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     issue_i,
  input  reg_idx_t issue_rd_i,
  input  logic     wb_i,
  input  reg_idx_t wb_rd_i,
  input  reg_idx_t rs_idx_i,
  input  reg_idx_t rt_idx_i,
  output sb_cnt_t  rs_cnt_o,
  output sb_cnt_t  rt_cnt_o,
  output logic     proto_err_o
);

  sb_cnt_t cnt_q [NUM_REGS];
  sb_cnt_t cnt_d [NUM_REGS];
  logic    inc;
  logic    dec;

  // Next-state counts: an issue and a commit to the same register cancel.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    cnt_d       = cnt_q;
    proto_err_o = 1'b0;
    inc         = issue_i && !(wb_i && (wb_rd_i == issue_rd_i));
    dec         = wb_i && !(issue_i && (wb_rd_i == issue_rd_i));
    if (inc) begin
      if (cnt_q[issue_rd_i] == SB_CNT_MAX) proto_err_o = 1'b1;
      else cnt_d[issue_rd_i] = cnt_q[issue_rd_i] + 2'd1;
    end
    if (dec) begin
      if (cnt_q[wb_rd_i] == 2'd0) proto_err_o = 1'b1;
      else cnt_d[wb_rd_i] = cnt_q[wb_rd_i] - 2'd1;
    end
  end

  // Count array register; reset discards every pending write.
  always_ff @(posedge clk) begin
    // NOTE: this array is cleared on reset on purpose: stale counts after
    // reset would stall decode forever, so it cannot map to an unreset RAM.
    // Sequential state uses non-blocking assignment so all entries update
    // together at the edge.
    if (rst) cnt_q <= '{default: '0};
    else     cnt_q <= cnt_d;
  end

  assign rs_cnt_o = cnt_q[rs_idx_i];
  assign rt_cnt_o = cnt_q[rt_idx_i];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU. Stalls PC and IF/ID with an
// ID/EX bubble on read-after-write hazards, and flushes IF/ID and ID/EX for a
// fixed window after a taken branch/jump in EX. A stall timeout or scoreboard
// protocol error sets the sticky deadlock flag.
// Optional macro HAZARD_PERF_EN adds perf_stalls / perf_flushes counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic             id_regw,
  input  logic             ex_taken,
  input  logic             wb_regw,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       state,
  output logic             deadlock
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stalls,
  output logic [31:0]      perf_flushes
`endif
);

  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(MAX_STALL);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);
  localparam logic [1:0]         FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_e           state_q;
  logic [1:0]          flush_cnt_q;
  logic [STALL_W-1:0]  stall_cnt_q;
  logic [STALL_W-1:0]  stall_cnt_d;
  logic                deadlock_q;
  logic                deadlock_d;

  sb_cnt_t rs_cnt;
  sb_cnt_t rt_cnt;
  logic    sb_err;
  logic    sb_hazard;
  logic    flush_active;
  logic    hazard_stall;
  logic    issue;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue),
    .issue_rd_i (id_rd),
    .wb_i       (wb_regw),
    .wb_rd_i    (wb_rd),
    .rs_idx_i   (id_rs),
    .rt_idx_i   (id_rt),
    .rs_cnt_o   (rs_cnt),
    .rt_cnt_o   (rt_cnt),
    .proto_err_o(sb_err)
  );

  // Hazard detection and front-end control; a flush always overrides a stall
  // and everything is held low while reset is asserted.
  always_comb begin
    sb_hazard    = id_valid && ((id_rs_used && (rs_cnt != 2'd0)) ||
                                (id_rt_used && (rt_cnt != 2'd0)));
    flush_active = !rst && (ex_taken || (state_q == ST_FLUSH));
    hazard_stall = !rst && sb_hazard && !flush_active;
    issue        = !rst && id_valid && id_regw && !sb_hazard && !flush_active;
    pc_stall     = hazard_stall;
    ifid_stall   = hazard_stall;
    idex_bubble  = hazard_stall || flush_active;
    ifid_flush   = flush_active;
  end

  // FSM with its flush-window counter; ex_taken wins in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
    end else if (ex_taken) begin
      // A one-cycle window is fully covered by the ex_taken cycle itself.
      state_q     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      flush_cnt_q <= FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_RUN:   if (sb_hazard) state_q <= ST_STALL;
        ST_STALL: if (!sb_hazard) state_q <= ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_q != 2'd0) flush_cnt_q <= flush_cnt_q - 2'd1;
          if (flush_cnt_q <= 2'd1) state_q <= ST_RUN;
        end
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Consecutive-stall counter and sticky deadlock next state.
  always_comb begin
    stall_cnt_d = '0;
    if (hazard_stall) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                               : stall_cnt_q + 1'b1;
    end
    deadlock_d = deadlock_q || sb_err ||
                 (hazard_stall && (stall_cnt_q >= STALL_LAST));
  end

  // Stall counter and deadlock registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign state    = state_q;
  assign deadlock = deadlock_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_flushes_q;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stalls_q  <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      if (hazard_stall) perf_stalls_q  <= perf_stalls_q + 32'd1;
      if (ex_taken)     perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, MAX_STALL=15).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge of the same cycle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_rs;
  logic [5:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [5:0] id_rd;
  logic       id_regw;
  logic       ex_taken;
  logic       wb_regw;
  logic [5:0] wb_rd;
  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_bubble;
  logic       ifid_flush;
  logic [1:0] state;
  logic       deadlock;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_regw    (id_regw),
    .ex_taken   (ex_taken),
    .wb_regw    (wb_regw),
    .wb_rd      (wb_rd),
    .pc_stall   (pc_stall),
    .ifid_stall (ifid_stall),
    .idex_bubble(idex_bubble),
    .ifid_flush (ifid_flush),
    .state      (state),
    .deadlock   (deadlock)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_flushes(perf_flushes)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid   = 1'b0;
    id_rs      = 6'd0;
    id_rt      = 6'd0;
    id_rs_used = 1'b0;
    id_rt_used = 1'b0;
    id_rd      = 6'd0;
    id_regw    = 1'b0;
    ex_taken   = 1'b0;
    wb_regw    = 1'b0;
    wb_rd      = 6'd0;
  endtask

  // Instruction writing rd with no source operands.
  task automatic writer(input logic [5:0] rd);
    id_valid = 1'b1;
    id_regw  = 1'b1;
    id_rd    = rd;
  endtask

  // Instruction reading rs (optionally also writing rd).
  task automatic reader(input logic [5:0] rs, input logic w, input logic [5:0] rd);
    id_valid   = 1'b1;
    id_rs      = rs;
    id_rs_used = 1'b1;
    id_regw    = w;
    id_rd      = rd;
  endtask

  task automatic wb(input logic [5:0] rd);
    wb_regw = 1'b1;
    wb_rd   = rd;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    idle();
    rst      = 1'b1;
    ex_taken = 1'b1;
    next_cycle();
    sample();
    check("rst_pc_stall", pc_stall, 0);
    check("rst_ifid_flush", ifid_flush, 0);
    check("rst_bubble", idex_bubble, 0);
    check("rst_state", state, 0);
    check("rst_deadlock", deadlock, 0);
    next_cycle();
    rst = 1'b0;
    idle();

    // ---------------- single RAW on r5 ----------------
    writer(6'd5);
    sample();
    check("t1_issue_nostall", pc_stall, 0);
    next_cycle();
    idle(); reader(6'd5, 1'b1, 6'd6);
    sample();
    check("t1_pc_stall", pc_stall, 1);
    check("t1_ifid_stall", ifid_stall, 1);
    check("t1_bubble", idex_bubble, 1);
    check("t1_noflush", ifid_flush, 0);
    check("t1_state_run", state, 0);
    next_cycle();
    idle(); reader(6'd5, 1'b1, 6'd6); wb(6'd5);
    sample();
    check("t1_state_stall", state, 1);
    check("t1_no_bypass", pc_stall, 1);
    next_cycle();
    idle(); reader(6'd5, 1'b1, 6'd6);
    sample();
    check("t1_released", pc_stall, 0);
    check("t1_no_bubble", idex_bubble, 0);
    next_cycle();
    idle(); wb(6'd6);
    sample();
    check("t1_back_run", state, 0);
    next_cycle();

    // ---------------- double write on r7 ----------------
    idle(); writer(6'd7);
    next_cycle();
    idle(); writer(6'd7);
    next_cycle();
    idle(); id_valid = 1'b1; id_rs = 6'd7; id_rs_used = 1'b0;
    sample();
    check("t2_unused_src", pc_stall, 0);
    next_cycle();
    idle(); reader(6'd7, 1'b0, 6'd0); wb(6'd7);
    sample();
    check("t2_cnt2_stall", pc_stall, 1);
    next_cycle();
    idle(); reader(6'd7, 1'b0, 6'd0); wb(6'd7);
    sample();
    check("t2_cnt1_stall", pc_stall, 1);
    next_cycle();
    idle(); id_valid = 1'b1; id_rt = 6'd7; id_rt_used = 1'b1;
    sample();
    check("t2_rt_released", pc_stall, 0);
    next_cycle();

    // ---------------- issue+wb same reg r9 ----------------
    idle(); writer(6'd9);
    next_cycle();
    idle(); writer(6'd9); wb(6'd9);
    sample();
    check("t3_issue_nostall", pc_stall, 0);
    next_cycle();
    idle(); reader(6'd9, 1'b0, 6'd0); wb(6'd9);
    sample();
    check("t3_cnt_kept", pc_stall, 1);
    next_cycle();
    idle(); reader(6'd9, 1'b0, 6'd0);
    sample();
    check("t3_cnt_was_one", pc_stall, 0);
    next_cycle();

    // ---------------- ex_taken during STALL ----------------
    idle(); writer(6'd10);
    next_cycle();
    idle(); reader(6'd10, 1'b1, 6'd11);
    sample();
    check("t4_stall", pc_stall, 1);
    next_cycle();
    idle(); reader(6'd10, 1'b1, 6'd11);
    sample();
    check("t4_state_stall", state, 1);
    next_cycle();
    idle(); reader(6'd10, 1'b1, 6'd11); ex_taken = 1'b1;
    sample();
    check("t4_flush", ifid_flush, 1);
    check("t4_bubble", idex_bubble, 1);
    check("t4_pc_nostall", pc_stall, 0);
    check("t4_ifid_nostall", ifid_stall, 0);
    next_cycle();
    idle(); writer(6'd11);
    sample();
    check("t4_state_flush", state, 2);
    check("t4_flush2", ifid_flush, 1);
    check("t4_pc_nostall2", pc_stall, 0);
    next_cycle();
    idle();
    sample();
    check("t4_state_run", state, 0);
    check("t4_flush_done", ifid_flush, 0);
    check("t4_bubble_done", idex_bubble, 0);
    next_cycle();
    idle(); reader(6'd11, 1'b0, 6'd0);
    sample();
    check("t4_not_counted", pc_stall, 0);
    next_cycle();
    idle(); wb(6'd10);
    next_cycle();

    // ---------------- ex_taken during FLUSH reloads ----------------
    idle(); ex_taken = 1'b1;
    next_cycle();
    idle(); ex_taken = 1'b1;
    sample();
    check("t4r_state_flush", state, 2);
    next_cycle();
    idle();
    sample();
    check("t4r_reloaded", state, 2);
    check("t4r_flush", ifid_flush, 1);
    next_cycle();
    idle();
    sample();
    check("t4r_run", state, 0);
    check("t4r_noflush", ifid_flush, 0);
    next_cycle();

    // ---------------- stall timeout ----------------
    idle(); writer(6'd12);
    next_cycle();
    for (int i = 1; i <= 15; i++) begin
      idle(); reader(6'd12, 1'b0, 6'd0);
      sample();
      if (i == 15) check("t5_no_deadlock_yet", deadlock, 0);
      next_cycle();
    end
    idle(); reader(6'd12, 1'b0, 6'd0);
    sample();
    check("t5_deadlock", deadlock, 1);
    check("t5_still_stall", pc_stall, 1);
    next_cycle();
    idle();
    next_cycle();
    idle();
    sample();
    check("t5_sticky", deadlock, 1);
    check("t5_fsm_runs", state, 0);
    next_cycle();
    idle(); reader(6'd12, 1'b0, 6'd0);
    next_cycle();
    idle(); reader(6'd12, 1'b0, 6'd0); rst = 1'b1;
    sample();
    check("t5_rst_pc_stall", pc_stall, 0);
    check("t5_rst_bubble", idex_bubble, 0);
    next_cycle();
    rst = 1'b0;
    idle(); reader(6'd12, 1'b0, 6'd0);
    sample();
    check("t5_sb_cleared", pc_stall, 0);
    check("t5_rst_state", state, 0);
    check("t5_rst_deadlock", deadlock, 0);
    next_cycle();

    // ---------------- protocol errors ----------------
    idle(); wb(6'd20);
    sample();
    check("t6_before_underflow", deadlock, 0);
    next_cycle();
    idle();
    sample();
    check("t6_underflow", deadlock, 1);
    next_cycle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); writer(6'd21);
      next_cycle();
    end
    idle();
    sample();
    check("t6_cnt3_ok", deadlock, 0);
    next_cycle();
    idle(); writer(6'd21);
    next_cycle();
    idle(); reader(6'd21, 1'b0, 6'd0);
    sample();
    check("t6_overflow", deadlock, 1);
    check("t6_saturated", pc_stall, 1);
    next_cycle();
    do_reset();

`ifdef HAZARD_PERF_EN
    // ---------------- performance counters ----------------
    idle();
    sample();
    check("perf_rst_stalls", perf_stalls, 0);
    check("perf_rst_flushes", perf_flushes, 0);
    next_cycle();
    idle(); writer(6'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); reader(6'd1, 1'b0, 6'd0);
      next_cycle();
    end
    idle(); ex_taken = 1'b1;
    next_cycle();
    idle();
    next_cycle();
    idle(); ex_taken = 1'b1;
    next_cycle();
    idle();
    next_cycle();
    idle();
    sample();
    check("perf_stalls", perf_stalls, 3);
    check("perf_flushes", perf_flushes, 2);
    next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
